// File: rtl/beatmap_pkg.sv
// Definitions shared by the beatmap generators, this scheduler and the note renderer.
// Latency: none; constants, types and a helper function only.
// Backpressure: none.
package beatmap_pkg;

  // Byte value that encodes lane 0; lane k is BASE + k * LANE_STEP.
  localparam int BASE       = 120;
  localparam int LANE_SHIFT = 2;
  localparam int LANE_STEP  = 1 << LANE_SHIFT;
  localparam int LANES      = 5;

  typedef logic [2:0] lane_t;

  // Debug counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// Generic synchronous FIFO with show-ahead read data and an occupancy count.
// Latency: an entry pushed on edge E is visible on pop_dat_o from the cycle after E.
// Backpressure: push on full is dropped unless a pop in the same cycle frees the slot; pop on empty is ignored.
module beat_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/beatmap_note_scheduler.sv
// Decodes beatmap bytes into lanes, queues them, and releases at most one note per beat.
// Latency: byte-in to note_valid is 3 clocks minimum (register, push, pop) when a beat is already pending.
// Backpressure: note held until note_ready; a blocked beat stays pending and later beats merge into it.
module beatmap_note_scheduler #(
  parameter int BASE        = beatmap_pkg::BASE,
  parameter int LANES       = beatmap_pkg::LANES,
  parameter int DEPTH       = 8,
  parameter int BEAT_PERIOD = 50_000_000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   data_en,
  input  logic [7:0]             data,
  output logic                   note_valid,
  output beatmap_pkg::lane_t     note_lane,
  input  logic                   note_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             bad_cnt,
  output logic [7:0]             ovf_cnt,
  output logic [7:0]             miss_cnt
);

  import beatmap_pkg::*;

  localparam int CW = $clog2(BEAT_PERIOD);

  logic          in_en_q;
  logic [7:0]    in_dat_q;
  logic [CW-1:0] beat_cnt_q,  beat_cnt_d;
  logic          beat_pend_q, beat_pend_d;
  logic          note_valid_q, note_valid_d;
  lane_t         note_lane_q,  note_lane_d;
  logic [7:0]    bad_q,  bad_d;
  logic [7:0]    ovf_q,  ovf_d;
  logic [7:0]    miss_q, miss_d;

  logic [8:0]    diff;
  logic [8:0]    lane_idx;
  logic          byte_ok;
  lane_t         dec_lane;

  logic          beat_wrap;
  logic          slot_free;
  logic          pop;
  logic          pend_done;
  logic          push;

  logic          fifo_full;
  logic          fifo_empty;
  lane_t         fifo_dat;

  // Stage 1: capture the raw byte and its qualifier every clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_en_q  <= 1'b0;
      in_dat_q <= '0;
    end else begin
      in_en_q  <= data_en;
      in_dat_q <= data;
    end
  end

  // Stage 2 decode in 9-bit arithmetic so bytes below BASE cannot wrap into a lane.
  always_comb begin
    diff     = {1'b0, in_dat_q} - 9'(BASE);
    lane_idx = diff >> LANE_SHIFT;
    byte_ok  = ({1'b0, in_dat_q} >= 9'(BASE)) &&
               (diff[LANE_SHIFT-1:0] == '0) &&
               (lane_idx < 9'(LANES));
    dec_lane = lane_t'(lane_idx);
  end

  // Beat timing and release decision; a pending beat retires on a pop or on an empty FIFO.
  always_comb begin
    beat_wrap   = (beat_cnt_q == CW'(BEAT_PERIOD - 1));
    slot_free   = !note_valid_q || note_ready;
    pop         = beat_pend_q && !fifo_empty && slot_free;
    pend_done   = beat_pend_q && (fifo_empty || slot_free);
    push        = in_en_q && byte_ok;
    beat_cnt_d  = beat_wrap ? '0 : beat_cnt_q + CW'(1);
    beat_pend_d = beat_wrap || (beat_pend_q && !pend_done);
  end

  // Output slot: a popped lane overwrites the slot; otherwise an accepted note empties it.
  always_comb begin
    note_valid_d = note_valid_q;
    note_lane_d  = note_lane_q;
    if (pop) begin
      note_valid_d = 1'b1;
      note_lane_d  = fifo_dat;
    end else if (note_ready) begin
      note_valid_d = 1'b0;
    end
  end

  // Debug counters; a beat wrapping onto a still-blocked beat counts as one miss.
  always_comb begin
    bad_d  = bad_q;
    ovf_d  = ovf_q;
    miss_d = miss_q;
    if (in_en_q && !byte_ok)            bad_d = sat_inc8(bad_q);
    if (push && fifo_full && !pop)      ovf_d = sat_inc8(ovf_q);
    if ((beat_pend_q && fifo_empty) ||
        (beat_wrap && beat_pend_q && !pend_done))
      miss_d = sat_inc8(miss_q);
  end

  // State registers for the timer, output slot and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt_q   <= '0;
      beat_pend_q  <= 1'b0;
      note_valid_q <= 1'b0;
      note_lane_q  <= '0;
      bad_q        <= '0;
      ovf_q        <= '0;
      miss_q       <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      beat_pend_q  <= beat_pend_d;
      note_valid_q <= note_valid_d;
      note_lane_q  <= note_lane_d;
      bad_q        <= bad_d;
      ovf_q        <= ovf_d;
      miss_q       <= miss_d;
    end
  end

  beat_fifo #(
    .WIDTH ($bits(lane_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (resetn),
    .push_i     (push),
    .push_dat_i (dec_lane),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign note_valid = note_valid_q;
  assign note_lane  = note_lane_q;
  assign bad_cnt    = bad_q;
  assign ovf_cnt    = ovf_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_beatmap_note_scheduler.sv
// Directed bench for the note scheduler: one fast-beat instance and one slow-beat instance.
// Latency: cycle numbers below count rising edges since reset release.
// Backpressure: note_ready is driven per scenario.
module tb_beatmap_note_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       f_resetn, f_data_en, f_note_ready, f_note_valid;
  logic [7:0] f_data, f_bad, f_ovf, f_miss;
  logic [2:0] f_note_lane;
  logic [3:0] f_level;

  logic       s_resetn, s_data_en, s_note_ready, s_note_valid;
  logic [7:0] s_data, s_bad, s_ovf, s_miss;
  logic [2:0] s_note_lane;
  logic [3:0] s_level;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  beatmap_note_scheduler #(.BASE(120), .LANES(5), .DEPTH(8), .BEAT_PERIOD(4)) u_fast (
    .clk(clk), .resetn(f_resetn), .data_en(f_data_en), .data(f_data),
    .note_valid(f_note_valid), .note_lane(f_note_lane), .note_ready(f_note_ready),
    .fifo_level(f_level), .bad_cnt(f_bad), .ovf_cnt(f_ovf), .miss_cnt(f_miss)
  );

  beatmap_note_scheduler #(.BASE(120), .LANES(5), .DEPTH(8), .BEAT_PERIOD(1000)) u_slow (
    .clk(clk), .resetn(s_resetn), .data_en(s_data_en), .data(s_data),
    .note_valid(s_note_valid), .note_lane(s_note_lane), .note_ready(s_note_ready),
    .fifo_level(s_level), .bad_cnt(s_bad), .ovf_cnt(s_ovf), .miss_cnt(s_miss)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic reset_fast();
    @(negedge clk);
    f_resetn = 1'b0; f_data_en = 1'b0; f_data = 8'd0;
    @(negedge clk);
    f_resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic reset_slow();
    @(negedge clk);
    s_resetn = 1'b0; s_data_en = 1'b0; s_data = 8'd0;
    @(negedge clk);
    s_resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset_fast();
    reset_slow();
    vec_cnt++; if (f_note_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_f_valid: got %b want 0", f_note_valid); end
    vec_cnt++; if (f_note_lane !== 3'd0) begin err_cnt++; $display("FAIL reset_f_lane: got %0d want 0", f_note_lane); end
    vec_cnt++; if (f_level !== 4'd0) begin err_cnt++; $display("FAIL reset_f_level: got %0d want 0", f_level); end
    vec_cnt++; if ({f_bad, f_ovf, f_miss} !== 24'd0) begin err_cnt++; $display("FAIL reset_f_cnts: got %h want 0", {f_bad, f_ovf, f_miss}); end
    vec_cnt++; if (s_note_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_s_valid: got %b want 0", s_note_valid); end
    vec_cnt++; if (s_level !== 4'd0) begin err_cnt++; $display("FAIL reset_s_level: got %0d want 0", s_level); end
    vec_cnt++; if ({s_bad, s_ovf, s_miss} !== 24'd0) begin err_cnt++; $display("FAIL reset_s_cnts: got %h want 0", {s_bad, s_ovf, s_miss}); end
  endtask

  // Lanes 0..4 streamed back to back; one note per beat at cycles 5, 9, 13, 17, 21.
  task automatic test_stream();
    reset_fast();
    f_note_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_data_en = 1'b1; f_data = 8'(120 + 4 * i);
      step();
    end
    f_data_en = 1'b0;
    vec_cnt++; if (f_note_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_first_valid: got %b want 1", f_note_valid); end
    vec_cnt++; if (f_note_lane !== 3'd0) begin err_cnt++; $display("FAIL stream_first_lane: got %0d want 0", f_note_lane); end
    vec_cnt++; if (f_level !== 4'd3) begin err_cnt++; $display("FAIL stream_level5: got %0d want 3", f_level); end
    step();
    vec_cnt++; if (f_note_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_accept: got %b want 0", f_note_valid); end
    vec_cnt++; if (f_level !== 4'd4) begin err_cnt++; $display("FAIL stream_level6: got %0d want 4", f_level); end
    for (int i = 1; i < 5; i++) begin
      run_to(4 + 4 * i);
      vec_cnt++; if (f_note_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_idle cyc%0d: got %b want 0", cyc, f_note_valid); end
      step();
      vec_cnt++; if (f_note_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_valid cyc%0d: got %b want 1", cyc, f_note_valid); end
      vec_cnt++; if (f_note_lane !== 3'(i)) begin err_cnt++; $display("FAIL stream_lane cyc%0d: got %0d want %0d", cyc, f_note_lane, i); end
      vec_cnt++; if (f_level !== 4'(4 - i)) begin err_cnt++; $display("FAIL stream_level cyc%0d: got %0d want %0d", cyc, f_level, 4 - i); end
    end
    vec_cnt++; if (f_bad !== 8'd0) begin err_cnt++; $display("FAIL stream_bad: got %0d want 0", f_bad); end
    vec_cnt++; if (f_miss !== 8'd0) begin err_cnt++; $display("FAIL stream_miss: got %0d want 0", f_miss); end
  endtask

  // 130 (misaligned), 119 (below BASE), 140 (lane 5 out of range) are all rejected.
  task automatic test_bad_bytes();
    logic [7:0] bb [3];
    bb = '{8'd130, 8'd119, 8'd140};
    reset_fast();
    f_note_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_data_en = 1'b1; f_data = bb[i];
      step();
    end
    f_data_en = 1'b0;
    step();
    vec_cnt++; if (f_bad !== 8'd3) begin err_cnt++; $display("FAIL bad_cnt: got %0d want 3", f_bad); end
    vec_cnt++; if (f_level !== 4'd0) begin err_cnt++; $display("FAIL bad_level: got %0d want 0", f_level); end
    vec_cnt++; if (f_miss !== 8'd0) begin err_cnt++; $display("FAIL bad_miss4: got %0d want 0", f_miss); end
    step();
    vec_cnt++; if (f_miss !== 8'd1) begin err_cnt++; $display("FAIL bad_miss5: got %0d want 1", f_miss); end
    run_to(8);
    vec_cnt++; if (f_miss !== 8'd1) begin err_cnt++; $display("FAIL bad_miss8: got %0d want 1", f_miss); end
    step();
    vec_cnt++; if (f_miss !== 8'd2) begin err_cnt++; $display("FAIL bad_miss9: got %0d want 2", f_miss); end
    vec_cnt++; if (f_note_valid !== 1'b0) begin err_cnt++; $display("FAIL bad_valid: got %b want 0", f_note_valid); end
  endtask

  // Nine valid bytes into an 8-deep FIFO with no beat in reach: the ninth is dropped.
  task automatic test_overflow();
    reset_slow();
    s_note_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data_en = 1'b1; s_data = 8'(120 + 4 * (i % 5));
      step();
    end
    s_data_en = 1'b0;
    vec_cnt++; if (s_level !== 4'd8) begin err_cnt++; $display("FAIL ovf_level9: got %0d want 8", s_level); end
    vec_cnt++; if (s_ovf !== 8'd0) begin err_cnt++; $display("FAIL ovf_cnt9: got %0d want 0", s_ovf); end
    step();
    vec_cnt++; if (s_level !== 4'd8) begin err_cnt++; $display("FAIL ovf_level10: got %0d want 8", s_level); end
    vec_cnt++; if (s_ovf !== 8'd1) begin err_cnt++; $display("FAIL ovf_cnt10: got %0d want 1", s_ovf); end
    vec_cnt++; if (s_bad !== 8'd0) begin err_cnt++; $display("FAIL ovf_bad: got %0d want 0", s_bad); end
  endtask

  // Continues from the full FIFO: a push lands on the pop edge at cycle 1001.
  task automatic test_full_push_pop();
    run_to(999);
    vec_cnt++; if (s_note_valid !== 1'b0) begin err_cnt++; $display("FAIL fpp_valid999: got %b want 0", s_note_valid); end
    s_data_en = 1'b1; s_data = 8'd136;
    step();
    s_data_en = 1'b0;
    vec_cnt++; if (s_level !== 4'd8) begin err_cnt++; $display("FAIL fpp_level1000: got %0d want 8", s_level); end
    step();
    vec_cnt++; if (s_level !== 4'd8) begin err_cnt++; $display("FAIL fpp_level1001: got %0d want 8", s_level); end
    vec_cnt++; if (s_ovf !== 8'd1) begin err_cnt++; $display("FAIL fpp_ovf: got %0d want 1", s_ovf); end
    vec_cnt++; if (s_note_valid !== 1'b1) begin err_cnt++; $display("FAIL fpp_valid: got %b want 1", s_note_valid); end
    vec_cnt++; if (s_note_lane !== 3'd0) begin err_cnt++; $display("FAIL fpp_lane: got %0d want 0", s_note_lane); end
    vec_cnt++; if (s_miss !== 8'd0) begin err_cnt++; $display("FAIL fpp_miss: got %0d want 0", s_miss); end
  endtask

  // Slot blocked across beats at 8, 12, 16: two merged beats count as misses.
  task automatic test_backpressure();
    int exp_miss;
    reset_fast();
    f_note_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f_data_en = 1'b1; f_data = 8'(120 + 4 * i);
      step();
    end
    f_data_en = 1'b0;
    vec_cnt++; if (f_note_valid !== 1'b1 || f_note_lane !== 3'd0) begin err_cnt++; $display("FAIL bp_first: got v%b l%0d want v1 l0", f_note_valid, f_note_lane); end
    for (int c = 6; c <= 16; c++) begin
      step();
      exp_miss = (c >= 16) ? 2 : ((c >= 12) ? 1 : 0);
      vec_cnt++; if (f_note_valid !== 1'b1 || f_note_lane !== 3'd0) begin err_cnt++; $display("FAIL bp_hold cyc%0d: got v%b l%0d want v1 l0", cyc, f_note_valid, f_note_lane); end
      vec_cnt++; if (f_level !== 4'd4) begin err_cnt++; $display("FAIL bp_level cyc%0d: got %0d want 4", cyc, f_level); end
      vec_cnt++; if (f_miss !== 8'(exp_miss)) begin err_cnt++; $display("FAIL bp_miss cyc%0d: got %0d want %0d", cyc, f_miss, exp_miss); end
    end
    f_note_ready = 1'b1;
    step();
    vec_cnt++; if (f_note_valid !== 1'b1 || f_note_lane !== 3'd1) begin err_cnt++; $display("FAIL bp_release: got v%b l%0d want v1 l1", f_note_valid, f_note_lane); end
    vec_cnt++; if (f_level !== 4'd3) begin err_cnt++; $display("FAIL bp_release_level: got %0d want 3", f_level); end
    step();
    vec_cnt++; if (f_note_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_accept: got %b want 0", f_note_valid); end
    for (int i = 2; i < 5; i++) begin
      run_to(4 * i + 12);
      step();
      vec_cnt++; if (f_note_valid !== 1'b1 || f_note_lane !== 3'(i)) begin err_cnt++; $display("FAIL bp_drain cyc%0d: got v%b l%0d want v1 l%0d", cyc, f_note_valid, f_note_lane, i); end
      vec_cnt++; if (f_level !== 4'(4 - i)) begin err_cnt++; $display("FAIL bp_drain_level cyc%0d: got %0d want %0d", cyc, f_level, 4 - i); end
    end
    vec_cnt++; if (f_miss !== 8'd2) begin err_cnt++; $display("FAIL bp_miss_end: got %0d want 2", f_miss); end
  endtask

  // Reset pulled mid-stream with a note out and two queued, then first note timing after release.
  task automatic test_async_reset();
    logic [7:0] rb [4];
    rb = '{8'd130, 8'd120, 8'd124, 8'd128};
    reset_fast();
    f_note_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_data_en = 1'b1; f_data = rb[i];
      step();
    end
    f_data_en = 1'b0;
    step();
    vec_cnt++; if (f_note_valid !== 1'b1 || f_level !== 4'd2 || f_bad !== 8'd1) begin err_cnt++; $display("FAIL ar_pre: got v%b lvl%0d bad%0d want v1 lvl2 bad1", f_note_valid, f_level, f_bad); end
    f_note_ready = 1'b0;
    f_resetn = 1'b0;
    #1;
    vec_cnt++; if (f_note_valid !== 1'b0 || f_note_lane !== 3'd0) begin err_cnt++; $display("FAIL ar_note: got v%b l%0d want v0 l0", f_note_valid, f_note_lane); end
    vec_cnt++; if (f_level !== 4'd0) begin err_cnt++; $display("FAIL ar_level: got %0d want 0", f_level); end
    vec_cnt++; if ({f_bad, f_ovf, f_miss} !== 24'd0) begin err_cnt++; $display("FAIL ar_cnts: got %h want 0", {f_bad, f_ovf, f_miss}); end
    @(negedge clk);
    @(negedge clk);
    f_resetn = 1'b1;
    cyc = 0;
    f_note_ready = 1'b1;
    f_data_en = 1'b1; f_data = 8'd120;
    for (int c = 1; c <= 4; c++) begin
      step();
      f_data_en = 1'b0;
      vec_cnt++; if (f_note_valid !== 1'b0) begin err_cnt++; $display("FAIL ar_early cyc%0d: got %b want 0", cyc, f_note_valid); end
    end
    step();
    vec_cnt++; if (f_note_valid !== 1'b1 || f_note_lane !== 3'd0) begin err_cnt++; $display("FAIL ar_first: got v%b l%0d want v1 l0", f_note_valid, f_note_lane); end
    vec_cnt++; if (f_miss !== 8'd0) begin err_cnt++; $display("FAIL ar_miss: got %0d want 0", f_miss); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    f_resetn = 1'b0; f_data_en = 1'b0; f_data = 8'd0; f_note_ready = 1'b0;
    s_resetn = 1'b0; s_data_en = 1'b0; s_data = 8'd0; s_note_ready = 1'b0;
    test_reset();
    test_stream();
    test_bad_bytes();
    test_overflow();
    test_full_push_pop();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
